// File: rtl/uart_frame_rx_if.sv
// rtl/uart_frame_rx_if.sv - byte-in / frame-out bundle between UART receiver, assembler and consumer
interface uart_frame_rx_if #(
  parameter int FRAME_BYTES = 40
);
  logic                     uart_read_done;
  logic [7:0]               read_data;
  logic                     frame_ack;
  logic [8*FRAME_BYTES-1:0] data;
  logic                     frame_valid;
  logic                     overrun;
  logic                     timeout_err;
  logic [5:0]               byte_cnt;

  modport master (
    output uart_read_done, read_data, frame_ack,
    input  data, frame_valid, overrun, timeout_err, byte_cnt
  );

  modport slave (
    input  uart_read_done, read_data, frame_ack,
    output data, frame_valid, overrun, timeout_err, byte_cnt
  );
endinterface

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - packs FRAME_BYTES UART bytes LSB-first into one frame word with timeout resync
module uart_frame_rx #(
  parameter int FRAME_BYTES    = 40,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            rst,
  uart_frame_rx_if.slave  bus
);
  localparam int              TW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [5:0]      LAST  = 6'(FRAME_BYTES - 1);
  localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t                        state, next_state;
  logic                          rd_prev;
  logic                          capture;
  logic                          last_cap;
  logic                          in_recv;
  logic                          timeout_hit;
  logic [TW-1:0]                 tcnt;
  logic [5:0]                    byte_cnt_q;
  logic [FRAME_BYTES-1:0][7:0]   frame_buf;
  logic [8*FRAME_BYTES-1:0]      data_q;
  logic                          commit_pend;
  logic                          frame_valid_q;
  logic                          overrun_q;
  logic                          timeout_err_q;

  // Only a rising edge of uart_read_done is a new byte; rd_prev resets high so a stuck level is ignored.
  assign capture  = bus.uart_read_done & ~rd_prev;
  assign last_cap = capture && (byte_cnt_q == LAST);

  // Edge-detect history register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_prev <= 1'b1;
    else      rd_prev <= bus.uart_read_done;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // FSM next state: a frame closes on its last byte or on an inter-byte timeout.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (capture) next_state = RECV;
      RECV: if (last_cap || timeout_hit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: counter enable and timeout decode; a capture on the expiry edge wins.
  always_comb begin
    in_recv     = (state == RECV);
    timeout_hit = in_recv && !capture && (tcnt == TLAST);
  end

  // Inter-byte idle counter, only running while a partial frame is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        tcnt <= '0;
    else if (capture || timeout_hit) tcnt <= '0;
    else if (in_recv)                tcnt <= tcnt + TW'(1);
  end

  // Assembly buffer and fill count; stale bytes after a timeout are simply overwritten.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_q <= '0;
      frame_buf  <= '0;
    end else if (capture) begin
      frame_buf[byte_cnt_q] <= bus.read_data;
      byte_cnt_q            <= last_cap ? 6'd0 : byte_cnt_q + 6'd1;
    end else if (timeout_hit) begin
      byte_cnt_q <= '0;
    end
  end

  // Commit one edge after the last byte; data takes the pre-edge buffer so a new byte 0 cannot leak in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_pend   <= 1'b0;
      data_q        <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      commit_pend <= last_cap;
      if (commit_pend) begin
        data_q        <= frame_buf;
        frame_valid_q <= 1'b1;
        if (frame_valid_q && !bus.frame_ack) overrun_q <= 1'b1;
      end else if (bus.frame_ack) begin
        frame_valid_q <= 1'b0;
        overrun_q     <= 1'b0;
      end
    end
  end

  // One-cycle discard indication.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) timeout_err_q <= 1'b0;
    else      timeout_err_q <= timeout_hit;
  end

  assign bus.data        = data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.byte_cnt    = byte_cnt_q;
endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Receive-side frame assembler for the UART link. Collects FRAME_BYTES consecutive bytes from the UART byte receiver and packs them into one wide frame word. Byte order is LSB-first: the first byte received lands in data[7:0]. Sits between the UART receiver core and the application logic, with inter-byte timeout resync and an ack handshake toward the consumer.

## Interface
- FRAME_BYTES, 40, bytes per frame; frame width is 8*FRAME_BYTES (320).
- TIMEOUT_CYCLES, 50000, idle clocks after a byte before a partial frame is discarded; must be ≥2.
- clk  input  1  system clock; single clock domain.
- rst  input  1  asynchronous, active-low reset.
- uart_read_done  input  1  byte-ready from the UART receiver; only its rising edge counts, and may be a pulse or a level.
- read_data  input  8  received byte; valid in the cycle uart_read_done is first seen high.
- frame_ack  input  1  consumer acknowledge; clears frame_valid and overrun.
- data  output  8*FRAME_BYTES  last completed frame; held until the next commit.
- frame_valid  output  1  a completed frame is waiting; held until acked.
- overrun  output  1  sticky; a frame was committed while the previous one was unacked.
- timeout_err  output  1  one-cycle pulse when a partial frame is discarded.
- byte_cnt  output  6  bytes held in the partial frame (0..FRAME_BYTES-1).

## Operation
- Edge detect:
  - A register rd_prev samples uart_read_done every clock.
  - A capture happens at an edge where uart_read_done=1 and rd_prev=0.
  - rd_prev resets to 1, so a level already high when reset is released is not captured.
- Assembly buffer, separate from data:
  - On capture, read_data is written to buffer byte [byte_cnt] and byte_cnt increments.
- State IDLE (byte_cnt=0) and state RECV (byte_cnt>0):
  - IDLE→RECV on the first capture.
  - RECV→IDLE on the capture of byte FRAME_BYTES-1 (byte_cnt wraps to 0 and commit_pend is set).
  - RECV→IDLE on timeout.
- Commit:
  - At the edge after commit_pend is set: data ← buffer, frame_valid ← 1, commit_pend ← 0.
  - A capture on that same edge writes buffer byte 0 of the next frame. data receives the pre-edge buffer contents, so the new byte does not corrupt it.
- Handshake:
  - frame_ack=1 at an edge clears frame_valid and overrun.
  - If commit and frame_ack occur on the same edge, the commit wins: frame_valid=1 and overrun is left unchanged.
  - If a commit occurs while frame_valid=1 and frame_ack=0, overrun ← 1 and data is overwritten with the new frame.
- Timeout:
  - Counter tcnt clears on every capture and increments each cycle while in RECV.
  - Let E be the last capture edge. If no capture occurs at edges E+1 … E+TIMEOUT_CYCLES, then at edge E+TIMEOUT_CYCLES: byte_cnt ← 0, state ← IDLE, timeout_err ← 1 for one cycle.
  - If a capture coincides with edge E+TIMEOUT_CYCLES, the capture wins and no timeout occurs.
  - The counter does not run in IDLE.
  - Buffer contents are not cleared on timeout; they are overwritten by later captures.

## Timing
- Reset (asynchronous, rst=0):
  - data=0, frame_valid=0, overrun=0, timeout_err=0, byte_cnt=0.
  - Internally: state IDLE, tcnt=0, commit_pend=0, rd_prev=1.
  - Reset asserted mid-frame discards the partial frame immediately; no timeout_err is raised.
- Capture latency: byte_cnt updates at the capture edge (visible in the next cycle).
- Frame latency: frame_valid rises one clock after the capture edge of the last byte.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The design holds at any baud rate, provided captures are at least 2 clocks apart.

## Test plan
- Bytes 0x01..0x28 delivered as 1-cycle pulses spaced 100 clocks apart -> data[7:0]=0x01, data[319:312]=0x28, frame_valid=1 exactly 1 clock after the 40th capture, byte_cnt=0, overrun=0.
- 5 bytes, then silence for TIMEOUT_CYCLES (override to 200) -> timeout_err pulses for 1 cycle at edge E+200 and byte_cnt=0. A following 40-byte frame 0xA0..0xC7 yields data[7:0]=0xA0 with no mix of old bytes; a byte placed exactly at E+200 is captured (byte_cnt=6, no timeout_err).
- Two full frames with no frame_ack -> overrun=1 and data holds frame 2. Then frame_ack for 1 cycle -> frame_valid=0 and overrun=0. frame_ack asserted on the commit edge -> frame_valid stays 1.
- uart_read_done held high for 20 cycles per byte -> exactly 1 capture each (byte_cnt +1). uart_read_done high while rst releases -> no capture.
- rst pulsed low after byte 17 -> all outputs are 0 immediately. A following 40-byte frame is assembled from byte 0 correctly.
- The first byte of the next frame captured on the commit edge -> data is intact and the new buffer byte 0 equals that byte (byte_cnt=1).
